// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: runs one vend order end to end. It drives the slot motor
// until the product drops or the motor times out, then pays the change (or the
// refund after a failed drop) as timed hopper pulses, largest coin first.
module vend_dispense_ctrl #(
  parameter int MOTOR_TICKS = 500,
  parameter int COIN_TICKS  = 50,
  parameter int COIN_GAP    = 50
) (
  input  logic       clk1k,
  input  logic       clr,
  input  logic       req,
  input  logic [1:0] req_slot,
  input  logic [4:0] req_change,
  input  logic [4:0] req_refund,
  input  logic       drop_sense,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] motor,
  output logic       coin10,
  output logic       coin5,
  output logic       coin1
);

  localparam int MAX_MC = (MOTOR_TICKS > COIN_TICKS) ? MOTOR_TICKS : COIN_TICKS;
  localparam int MAX_T  = (MAX_MC > COIN_GAP) ? MAX_MC : COIN_GAP;
  localparam int CW     = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOTOR,
    S_PAY,
    S_COIN,
    S_GAP,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_change;
  logic [4:0]    r_refund;
  logic [4:0]    r_remain;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [3:0]    r_motor;
  logic          r_coin10;
  logic          r_coin5;
  logic          r_coin1;

  // One shared down-counter times the motor, the coin pulse and the gap;
  // it is reloaded on every phase change, so a count of 1 marks the last cycle.
  logic w_cnt_last;
  assign w_cnt_last = (r_cnt == CW'(1));

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign motor  = r_motor;
  assign coin10 = r_coin10;
  assign coin5  = r_coin5;
  assign coin1  = r_coin1;

  // Order sequencer: all outputs are registered alongside the state.
  always_ff @(posedge clk1k or posedge clr) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_change <= '0;
      r_refund <= '0;
      r_remain <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_motor  <= '0;
      r_coin10 <= 1'b0;
      r_coin5  <= 1'b0;
      r_coin1  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_change <= req_change;
            r_refund <= req_refund;
            r_err    <= 1'b0;
            r_cnt    <= CW'(MOTOR_TICKS);
            r_motor  <= 4'b0001 << req_slot;
            r_busy   <= 1'b1;
            r_state  <= S_MOTOR;
          end
        end
        S_MOTOR: begin
          // A drop seen on the expiry edge still counts as a successful vend.
          if (drop_sense) begin
            r_remain <= r_change;
            r_motor  <= '0;
            r_state  <= S_PAY;
          end else if (w_cnt_last) begin
            r_err    <= 1'b1;
            r_remain <= r_refund;
            r_motor  <= '0;
            r_state  <= S_PAY;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_PAY: begin
          r_cnt <= CW'(COIN_TICKS);
          if (r_remain >= 5'd10) begin
            r_coin10 <= 1'b1;
            r_remain <= r_remain - 5'd10;
            r_state  <= S_COIN;
          end else if (r_remain >= 5'd5) begin
            r_coin5  <= 1'b1;
            r_remain <= r_remain - 5'd5;
            r_state  <= S_COIN;
          end else if (r_remain != 5'd0) begin
            r_coin1  <= 1'b1;
            r_remain <= r_remain - 5'd1;
            r_state  <= S_COIN;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_COIN: begin
          if (w_cnt_last) begin
            r_coin10 <= 1'b0;
            r_coin5  <= 1'b0;
            r_coin1  <= 1'b0;
            r_cnt    <= CW'(COIN_GAP);
            r_state  <= S_GAP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_GAP: begin
          if (w_cnt_last) begin
            r_state <= S_PAY;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: self-checking bench. Each order's expected output
// trace is built from the vending rules (motor time, greedy coin list, fixed
// per-coin cost) and compared cycle by cycle against the DUT.
module tb_vend_dispense_ctrl;

  localparam int M = 8;
  localparam int T = 2;
  localparam int G = 3;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] motor;
    logic       c10;
    logic       c5;
    logic       c1;
  } obs_t;

  logic       clk1k;
  logic       clr;
  logic       req;
  logic [1:0] req_slot;
  logic [4:0] req_change;
  logic [4:0] req_refund;
  logic       drop_sense;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] motor;
  logic       coin10;
  logic       coin5;
  logic       coin1;

  int   total;
  int   bad;
  logic exp_err;
  obs_t exp_q[$];

  vend_dispense_ctrl #(
    .MOTOR_TICKS(M),
    .COIN_TICKS (T),
    .COIN_GAP   (G)
  ) dut (
    .clk1k     (clk1k),
    .clr       (clr),
    .req       (req),
    .req_slot  (req_slot),
    .req_change(req_change),
    .req_refund(req_refund),
    .drop_sense(drop_sense),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .motor     (motor),
    .coin10    (coin10),
    .coin5     (coin5),
    .coin1     (coin1)
  );

  initial clk1k = 1'b0;
  always #5 clk1k = ~clk1k;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.busy  = busy;
    o.done  = done;
    o.err   = err;
    o.motor = motor;
    o.c10   = coin10;
    o.c5    = coin5;
    o.c1    = coin1;
    return o;
  endfunction

  // Expected trace from the cycle after accept through the first idle cycle.
  // doff = edge (counted from accept) at which the drop is seen; 0 = never.
  task automatic build_trace(input int slot, input int chg, input int rfd, input int doff);
    obs_t o;
    bit   fail;
    int   md;
    int   amt;
    int   v;
    exp_q.delete();
    fail = (doff == 0);
    md   = fail ? M : doff;
    amt  = fail ? rfd : chg;
    for (int i = 0; i < md; i++) begin
      o = '0; o.busy = 1'b1; o.motor = 4'(1 << slot);
      exp_q.push_back(o);
    end
    while (amt > 0) begin
      v = (amt >= 10) ? 10 : (amt >= 5) ? 5 : 1;
      o = '0; o.busy = 1'b1; o.err = fail;
      exp_q.push_back(o);
      o.c10 = (v == 10); o.c5 = (v == 5); o.c1 = (v == 1);
      for (int i = 0; i < T; i++) exp_q.push_back(o);
      o.c10 = 1'b0; o.c5 = 1'b0; o.c1 = 1'b0;
      for (int i = 0; i < G; i++) exp_q.push_back(o);
      amt -= v;
    end
    o = '0; o.busy = 1'b1; o.err = fail;
    exp_q.push_back(o);
    o.done = 1'b1;
    exp_q.push_back(o);
    o = '0; o.err = fail;
    exp_q.push_back(o);
  endtask

  // Issue one order from an idle negedge and check every following cycle.
  // noise: 0 quiet, 1 random req/fields while busy, 2 req held high while busy.
  // abort_k >= 0 pulses clr right after that cycle's check.
  task automatic run_order(input string name, input int slot, input int chg, input int rfd,
                           input int doff, input int noise, input int abort_k);
    obs_t o;
    obs_t z;
    int   md;
    bit   last;
    build_trace(slot, chg, rfd, doff);
    md = (doff == 0) ? M : doff;
    req = 1'b1; req_slot = 2'(slot); req_change = 5'(chg); req_refund = 5'(rfd);
    drop_sense = 1'b0;
    @(posedge clk1k);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk1k);
      o = sample();
      total++;
      if (o !== exp_q[k]) begin
        bad++;
        $display("FAIL %s cycle=%0d got=%b expected=%b", name, k, o, exp_q[k]);
      end
      if (k == abort_k) begin
        z = '0;
        clr = 1'b1;
        #1;
        o = sample();
        total++;
        if (o !== z) begin
          bad++;
          $display("FAIL %s_async_clr got=%b expected=%b", name, o, z);
        end
        req = 1'b0; drop_sense = 1'b0;
        for (int c = 0; c < 6; c++) begin
          if (c == 2) clr = 1'b0;
          @(negedge clk1k);
          o = sample();
          total++;
          if (o !== z) begin
            bad++;
            $display("FAIL %s_after_clr cycle=%0d got=%b expected=%b", name, c, o, z);
          end
        end
        exp_err = 1'b0;
        return;
      end
      last = (k == exp_q.size() - 1);
      if (noise == 0 || last) begin
        req = 1'b0;
      end else begin
        req = (noise == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        req_slot = 2'($urandom_range(0, 3));
        req_change = 5'($urandom_range(0, 31));
        req_refund = 5'($urandom_range(0, 31));
      end
      if (k < md - 1) drop_sense = 1'b0;
      else if (k == md - 1) drop_sense = (doff != 0);
      else drop_sense = (noise != 0 && !last) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    exp_err = (doff == 0);
  endtask

  task automatic test_reset();
    obs_t o;
    obs_t z;
    z = '0;
    clr = 1'b1; req = 1'b1; req_slot = 2'd1; req_change = 5'd7; req_refund = 5'd9;
    drop_sense = 1'b0;
    #1;
    o = sample();
    total++;
    if (o !== z) begin
      bad++;
      $display("FAIL reset_immediate got=%b expected=%b", o, z);
    end
    repeat (3) @(posedge clk1k);
    @(negedge clk1k);
    o = sample();
    total++;
    if (o !== z) begin
      bad++;
      $display("FAIL reset_held got=%b expected=%b", o, z);
    end
    req = 1'b0;
    clr = 1'b0;
    repeat (2) begin
      @(negedge clk1k);
      o = sample();
      total++;
      if (o !== z) begin
        bad++;
        $display("FAIL reset_idle got=%b expected=%b", o, z);
      end
    end
    exp_err = 1'b0;
  endtask

  task automatic test_drop_change();
    run_order("drop_change", 2, 17, 24, 4, 0, -1);
  endtask

  task automatic test_timeout_refund();
    run_order("timeout_refund", 1, 3, 16, 0, 0, -1);
  endtask

  task automatic test_zero_change();
    run_order("zero_change", 3, 0, 9, 3, 0, -1);
  endtask

  task automatic test_back_to_back();
    run_order("drop_at_expiry", 3, 23, 4, M, 2, -1);
    run_order("back_to_back", 0, 12, 30, 5, 0, -1);
  endtask

  task automatic test_clr_mid_coin();
    run_order("clr_mid_coin", 3, 17, 20, 2, 0, 3);
    run_order("after_clr", 0, 5, 0, 2, 0, -1);
  endtask

  task automatic test_random();
    int slot;
    int chg;
    int rfd;
    int doff;
    for (int n = 0; n < 40; n++) begin
      slot = $urandom_range(0, 3);
      chg  = $urandom_range(0, 31);
      rfd  = $urandom_range(0, 31);
      doff = $urandom_range(0, M);
      run_order("random", slot, chg, rfd, doff, 1, -1);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_err = 1'b0;
    test_reset();
    test_drop_change();
    test_timeout_refund();
    test_zero_change();
    test_back_to_back();
    test_clr_mid_coin();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
